// File: rtl/padding_layer_sched_pkg.sv
// rtl/padding_layer_sched_pkg.sv - shared descriptor layout, FSM states and beat helpers for the padding layer sequencer
package padding_layer_sched_pkg;

  // 34-bit descriptor: {zero_num[2:0], zero_point[7:0], pad_en, ch_in[9:0], row_in[11:0]}
  localparam int DESC_W     = 34;
  localparam int ROW_LSB    = 0;
  localparam int ROW_W      = 12;
  localparam int CH_LSB     = 12;
  localparam int CH_W       = 10;
  localparam int PAD_EN_BIT = 22;
  localparam int ZP_LSB     = 23;
  localparam int ZP_W       = 8;
  localparam int ZN_LSB     = 31;
  localparam int ZN_W       = 3;

  // Channel count to channel-group conversion used for the beat count
  localparam int CH_SHIFT = 4;
  localparam int CHT_W    = CH_W - CH_SHIFT;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_START  = 3'd3,
    ST_RUN    = 3'd4,
    ST_FLUSH  = 3'd5,
    ST_NEXT   = 3'd6
  } state_t;

  // Output rows of a padded layer; wraps at 12 bits by design
  function automatic logic [ROW_W-1:0] padded_rows(input logic [ROW_W-1:0] row,
                                                   input logic pad_en,
                                                   input logic [ZN_W-1:0] zero_num);
    return pad_en ? row + ROW_W'({zero_num, 1'b0}) : row;
  endfunction

endpackage

// File: rtl/pad_desc_ram.sv
// rtl/pad_desc_ram.sv - per-layer descriptor register file, synchronous write, registered read
module pad_desc_ram import padding_layer_sched_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DESC_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [DESC_W-1:0] rd_data
);

  logic [DESC_W-1:0] mem [DEPTH];

  // Host write and one-cycle registered read; a same-cycle write is seen on the following read
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/padding_layer_sched.sv
// rtl/padding_layer_sched.sv - padding stage layer sequencer; PAD_SCHED_PERF_EN adds perf_cycles
module padding_layer_sched import padding_layer_sched_pkg::*; #(
  parameter int LAYER_DEPTH        = 16,
  parameter int WIDTH_FEATURE_SIZE = 12,
  parameter int WIDTH_CHANNEL_NUM  = 10,
  parameter int WIDTH_DATA         = 8,
  parameter int SETTLE_CYCLES      = 2,
  localparam int AW                = $clog2(LAYER_DEPTH)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  input  logic [AW-1:0]                 cfg_addr,
  input  logic [DESC_W-1:0]             cfg_data,
  input  logic                          go,
  input  logic [AW:0]                   num_layers,
  input  logic                          abort,
  input  logic                          pad_wr_en,
  output logic [WIDTH_FEATURE_SIZE-1:0] pad_row_num,
  output logic [WIDTH_CHANNEL_NUM-1:0]  pad_ch_num,
  output logic                          pad_en,
  output logic [WIDTH_DATA-1:0]         pad_zero_point,
  output logic [2:0]                    pad_zero_num,
  output logic                          pad_start,
  output logic                          pad_next_reg,
  output logic                          busy,
  output logic [AW-1:0]                 layer_idx,
  output logic                          layer_done,
  output logic                          seq_done
`ifdef PAD_SCHED_PERF_EN
  ,
  output logic [31:0]                   perf_cycles
`endif
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);

  state_t            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic              go_q;
  logic              go_take;
  logic [AW:0]       nl_q;
  logic [SW-1:0]     settle_q;
  logic [31:0]       beat_cnt;
  logic [31:0]       expected;
  logic [23:0]       sq_q;
  logic [CHT_W-1:0]  cht_q;
  logic              run_done;
  logic              start_d, next_reg_d, layer_done_d, seq_done_d;
  logic [DESC_W-1:0] rd_data;

  logic [ROW_W-1:0]  d_row;
  logic [CH_W-1:0]   d_ch;
  logic              d_pad_en;
  logic [ZP_W-1:0]   d_zp;
  logic [ZN_W-1:0]   d_zn;
  logic [ROW_W-1:0]  d_rows_out;

  // The read address follows the next layer index so the descriptor is ready in LOAD
  pad_desc_ram #(.DEPTH(LAYER_DEPTH), .AW(AW)) u_desc_ram (
    .clk     (clk),
    .we      (cfg_we),
    .wr_addr (cfg_addr),
    .wr_data (cfg_data),
    .rd_addr (idx_d),
    .rd_data (rd_data)
  );

  assign d_row      = rd_data[ROW_LSB +: ROW_W];
  assign d_ch       = rd_data[CH_LSB +: CH_W];
  assign d_pad_en   = rd_data[PAD_EN_BIT];
  assign d_zp       = rd_data[ZP_LSB +: ZP_W];
  assign d_zn       = rd_data[ZN_LSB +: ZN_W];
  assign d_rows_out = padded_rows(d_row, d_pad_en, d_zn);

  // go is only honoured in IDLE and only once until the FSM has reacted to it
  assign go_take  = go && (state_q == ST_IDLE) && !go_q;
  // A zero-beat layer leaves RUN immediately; otherwise leave on the final beat
  assign run_done = (beat_cnt == expected) || (pad_wr_en && (beat_cnt + 32'd1 == expected));
  assign layer_idx = idx_q;

  // Next-state and pulse decode; abort overrides everything outside IDLE
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    start_d      = 1'b0;
    next_reg_d   = 1'b0;
    layer_done_d = 1'b0;
    seq_done_d   = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      next_reg_d = 1'b1;
      seq_done_d = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (go_q) begin
            if (nl_q != '0) begin
              state_d = ST_LOAD;
              idx_d   = '0;
            end else begin
              seq_done_d = 1'b1;
            end
          end
        end
        ST_LOAD:   state_d = ST_SETTLE;
        ST_SETTLE: begin
          if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_d = ST_START;
            start_d = 1'b1;
          end
        end
        ST_START:  state_d = ST_RUN;
        ST_RUN: begin
          if (run_done) begin
            state_d      = ST_FLUSH;
            next_reg_d   = 1'b1;
            layer_done_d = 1'b1;
          end
        end
        ST_FLUSH:  state_d = ST_NEXT;
        ST_NEXT: begin
          if ((AW+1)'(idx_q) + (AW+1)'(1) == nl_q) begin
            state_d    = ST_IDLE;
            seq_done_d = 1'b1;
          end else begin
            state_d = ST_LOAD;
            idx_d   = idx_q + AW'(1);
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State, counters and registered pulse outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      go_q         <= 1'b0;
      nl_q         <= '0;
      settle_q     <= '0;
      beat_cnt     <= '0;
      pad_start    <= 1'b0;
      pad_next_reg <= 1'b0;
      layer_done   <= 1'b0;
      seq_done     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      go_q         <= go_take;
      if (go_take) begin
        nl_q <= num_layers;
      end
      settle_q     <= (state_q == ST_SETTLE) ? settle_q + SW'(1) : '0;
      beat_cnt     <= (state_q == ST_RUN) ? beat_cnt + 32'(pad_wr_en) : '0;
      pad_start    <= start_d;
      pad_next_reg <= next_reg_d;
      layer_done   <= layer_done_d;
      seq_done     <= seq_done_d;
      busy         <= (state_d != ST_IDLE);
    end
  end

  // Descriptor lands on the stage config in LOAD along with the first multiply stage
  always_ff @(posedge clk) begin
    if (rst) begin
      pad_row_num    <= '0;
      pad_ch_num     <= '0;
      pad_en         <= 1'b0;
      pad_zero_point <= '0;
      pad_zero_num   <= '0;
      sq_q           <= '0;
      cht_q          <= '0;
    end else if (state_q == ST_LOAD) begin
      pad_row_num    <= WIDTH_FEATURE_SIZE'(d_row);
      pad_ch_num     <= WIDTH_CHANNEL_NUM'(d_ch);
      pad_en         <= d_pad_en;
      pad_zero_point <= WIDTH_DATA'(d_zp);
      pad_zero_num   <= d_zn;
      sq_q           <= 24'(d_rows_out) * 24'(d_rows_out);
      cht_q          <= CHT_W'(d_ch >> CH_SHIFT);
    end
  end

  // Second multiply stage; settles inside the SETTLE window before RUN reads it
  always_ff @(posedge clk) begin
    if (rst) begin
      expected <= '0;
    end else begin
      expected <= 32'(sq_q) * 32'(cht_q);
    end
  end

`ifdef PAD_SCHED_PERF_EN
  logic [31:0] run_cyc;

  // Clocks since pad_start, captured when the layer's last beat lands
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cyc     <= '0;
      perf_cycles <= '0;
    end else begin
      if (state_q == ST_START) begin
        run_cyc <= 32'd1;
      end else if ((state_q == ST_RUN) && (run_cyc != '1)) begin
        run_cyc <= run_cyc + 32'd1;
      end
      if (layer_done_d) begin
        perf_cycles <= run_cyc;
      end
    end
  end
`endif

endmodule

// File: tb/tb_padding_layer_sched.sv
// tb/tb_padding_layer_sched.sv - self-checking bench for padding_layer_sched
module tb_padding_layer_sched;

  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we;
  logic [3:0]  cfg_addr;
  logic [33:0] cfg_data;
  logic        go;
  logic [4:0]  num_layers;
  logic        abort;
  logic        pad_wr_en;
  logic [11:0] pad_row_num;
  logic [9:0]  pad_ch_num;
  logic        pad_en;
  logic [7:0]  pad_zero_point;
  logic [2:0]  pad_zero_num;
  logic        pad_start;
  logic        pad_next_reg;
  logic        busy;
  logic [3:0]  layer_idx;
  logic        layer_done;
  logic        seq_done;
`ifdef PAD_SCHED_PERF_EN
  logic [31:0] perf_cycles;
`endif

  int checks = 0;
  int failures = 0;
  logic [33:0] tbl [16];

  always #5 clk = ~clk;

  padding_layer_sched #(.SETTLE_CYCLES(S)) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_data       (cfg_data),
    .go             (go),
    .num_layers     (num_layers),
    .abort          (abort),
    .pad_wr_en      (pad_wr_en),
    .pad_row_num    (pad_row_num),
    .pad_ch_num     (pad_ch_num),
    .pad_en         (pad_en),
    .pad_zero_point (pad_zero_point),
    .pad_zero_num   (pad_zero_num),
    .pad_start      (pad_start),
    .pad_next_reg   (pad_next_reg),
    .busy           (busy),
    .layer_idx      (layer_idx),
    .layer_done     (layer_done),
    .seq_done       (seq_done)
`ifdef PAD_SCHED_PERF_EN
    ,
    .perf_cycles    (perf_cycles)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic logic [33:0] mk_desc(input int row, input int ch, input int pen,
                                          input int zp, input int zn);
    logic [11:0] r = 12'(row);
    logic [9:0]  c = 10'(ch);
    logic [7:0]  p = 8'(zp);
    logic [2:0]  z = 3'(zn);
    return {z, p, 1'(pen), c, r};
  endfunction

  // Beats the stage produces for a layer: (padded rows)^2 * (channels / 16)
  function automatic int exp_beats(input logic [33:0] d);
    int row, ch, zn, o;
    row = int'(d[11:0]);
    ch  = int'(d[21:12]);
    zn  = int'(d[33:31]);
    o   = d[22] ? (row + 2 * zn) % 4096 : row;
    return o * o * (ch / 16);
  endfunction

  task automatic write_desc(input int idx, input logic [33:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = 4'(idx);
    cfg_data = d;
    tbl[idx] = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  // Runs one go..seq_done sequence, feeding exactly the modelled number of beats per layer
  task automatic run_seq(input int n, input bit pre_beat);
    int layer = 0, starts = 0, dones = 0, seqs = 0;
    int want = 0, sent = 0, s_cyc = 0, nr_cyc = -1;
    bit running = 0, finished = 0;
    @(negedge clk);
    go = 1'b1;
    num_layers = 5'(n);
    for (int cyc = 1; cyc < 20000 && !finished; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      pad_wr_en = 1'b0;
      if (pad_start) begin
        starts++;
        if (starts == 1) check("start_latency", cyc, 3 + S);
        check("layer_idx", layer_idx, layer);
        check("row_num", pad_row_num, tbl[layer][11:0]);
        check("ch_num", pad_ch_num, tbl[layer][21:12]);
        check("pad_en", pad_en, tbl[layer][22]);
        check("zero_point", pad_zero_point, tbl[layer][30:23]);
        check("zero_num", pad_zero_num, tbl[layer][33:31]);
        want = exp_beats(tbl[layer]);
        sent = 0;
        s_cyc = cyc;
        running = 1;
        nr_cyc = (want == 0) ? cyc + 2 : -1;
        if (pre_beat) pad_wr_en = 1'b1;
      end else if (running && sent < want) begin
        if ($urandom_range(0, 3) != 0) begin
          pad_wr_en = 1'b1;
          sent++;
          if (sent == want) nr_cyc = cyc + 1;
        end
      end else if (pre_beat && layer == 0 && !running && cyc == 3) begin
        pad_wr_en = 1'b1;
      end
      if (pad_next_reg) begin
        check("next_reg_timing", cyc, nr_cyc);
        check("layer_done_with_next", layer_done, 1);
`ifdef PAD_SCHED_PERF_EN
        check("perf_cycles", perf_cycles, cyc - 1 - s_cyc);
`endif
        dones++;
        layer++;
        running = 0;
      end else if (layer_done) begin
        check("layer_done_without_next", layer_done, 0);
      end
      if (seq_done) begin
        seqs++;
        check("seq_done_after_last", layer, n);
        finished = 1;
      end
    end
    check("seq_timeout", finished, 1);
    check("start_count", starts, n);
    check("layer_done_count", dones, n);
    check("seq_done_count", seqs, 1);
    @(negedge clk);
    check("busy_after_seq", busy, 0);
    check("seq_done_single", seq_done, 0);
  endtask

  task automatic abort_test();
    int sent = 0;
    bit started = 0, fired = 0;
    write_desc(0, mk_desc(4, 16, 1, 8'h5A, 1));
    @(negedge clk);
    go = 1'b1;
    num_layers = 5'd1;
    for (int cyc = 1; cyc < 200 && !fired; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      pad_wr_en = 1'b0;
      if (pad_start) begin
        started = 1;
      end else if (started && sent < 10) begin
        pad_wr_en = 1'b1;
        sent++;
      end else if (sent == 10) begin
        abort = 1'b1;
        fired = 1;
      end
    end
    check("abort_reached", fired, 1);
    @(negedge clk);
    abort = 1'b0;
    check("abort_next_reg", pad_next_reg, 1);
    check("abort_seq_done", seq_done, 1);
    check("abort_busy", busy, 0);
    check("abort_no_layer_done", layer_done, 0);
    @(negedge clk);
    check("abort_next_reg_single", pad_next_reg, 0);
    run_seq(1, 0);
  endtask

  task automatic zero_layers_test();
    int seqs = 0, starts = 0, busy_seen = 0;
    @(negedge clk);
    go = 1'b1;
    num_layers = 5'd0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      seqs += int'(seq_done);
      starts += int'(pad_start);
      busy_seen += int'(busy);
    end
    check("nl0_seq_done", seqs, 1);
    check("nl0_no_start", starts, 0);
    check("nl0_not_busy", busy_seen, 0);
  endtask

  task automatic reset_mid_run_test();
    int sent = 0, stray = 0;
    bit started = 0;
    write_desc(0, mk_desc(5, 32, 0, 8'h77, 2));
    @(negedge clk);
    go = 1'b1;
    num_layers = 5'd1;
    for (int cyc = 1; cyc < 100 && sent < 5; cyc++) begin
      @(negedge clk);
      go = 1'b0;
      pad_wr_en = 1'b0;
      if (pad_start) started = 1;
      else if (started) begin
        pad_wr_en = 1'b1;
        sent++;
      end
    end
    check("rst_reached_run", sent, 5);
    @(negedge clk);
    pad_wr_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_outputs", {pad_row_num, pad_ch_num, pad_en, pad_zero_point, pad_zero_num,
                          pad_start, pad_next_reg, busy, layer_idx, layer_done, seq_done}, 0);
    for (int cyc = 0; cyc < 60; cyc++) begin
      @(negedge clk);
      pad_wr_en = 1'b1;
      stray += int'(pad_next_reg) + int'(layer_done) + int'(pad_start);
    end
    pad_wr_en = 1'b0;
    check("rst_no_stray_pulse", stray, 0);
  endtask

  initial begin
    rst = 1'b1;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    go = 1'b0;
    num_layers = '0;
    abort = 1'b0;
    pad_wr_en = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {pad_row_num, pad_ch_num, pad_en, pad_zero_point, pad_zero_num,
                            pad_start, pad_next_reg, busy, layer_idx, layer_done, seq_done}, 0);
    rst = 1'b0;

    // Single padded layer: 36 beats
    write_desc(0, mk_desc(4, 16, 1, 8'h10, 1));
    run_seq(1, 0);

    // No padding, stray beats before and at pad_start: 50 beats
    write_desc(0, mk_desc(5, 32, 0, 8'h20, 3));
    run_seq(1, 1);

    // Three distinct layers, including a 12-bit row wrap
    write_desc(0, mk_desc(3, 16, 1, 8'h11, 2));
    write_desc(1, mk_desc(6, 40, 0, 8'h22, 0));
    write_desc(2, mk_desc(4095, 48, 1, 8'h33, 1));
    run_seq(3, 0);

    // Channel count below one group: no beats expected
    write_desc(0, mk_desc(7, 8, 1, 8'h44, 1));
    run_seq(1, 0);

    zero_layers_test();
    abort_test();

    // Random sequences
    for (int r = 0; r < 4; r++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        write_desc(i, mk_desc($urandom_range(1, 6), $urandom_range(0, 63), $urandom_range(0, 1),
                              $urandom_range(0, 255), $urandom_range(0, 3)));
      end
      run_seq(n, r[0]);
    end

    reset_mid_run_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
